// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game button path.
package simon_pkg;

  localparam int LOCKOUT_50MS = 2500000;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    YELLOW = 2'd2,
    BLUE   = 2'd3
  } colour_t;

  typedef struct packed {
    colour_t code;
    logic    multi;
  } event_t;

endpackage

// File: rtl/button_event_queue_if.sv
// Event stream from the button queue to the game controller (valid/ready).
interface button_event_queue_if #(
  parameter int CODE_W = 2
);
  logic              valid;
  logic              ready;
  logic [CODE_W-1:0] code;
  logic              multi;

  modport master (output valid, output code, output multi, input ready);
  modport slave  (input valid, input code, input multi, output ready);
endinterface

// File: rtl/event_fifo.sv
// Generic first-word-fall-through FIFO; the head word is visible whenever not empty.
module event_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock_signal,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock_signal) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock_signal or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/button_event_queue.sv
// Press lockout, priority encoding and buffering of button events for the game controller.
module button_event_queue
  import simon_pkg::*;
#(
  parameter int NUM_BUTTONS    = 4,
  parameter int LOCKOUT_CYCLES = LOCKOUT_50MS,
  parameter int FIFO_DEPTH     = 4,
  localparam int CODE_W = $clog2(NUM_BUTTONS),
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1,
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1)
) (
  input  logic                   clock_signal,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] press_pulse,
  input  logic                   enable,
  input  logic                   flush,
  button_event_queue_if.master   evt,
  output logic                   lockout_active,
  output logic                   overflow,
  output logic [CNT_W-1:0]       event_count
);

  logic [LOCK_W-1:0] lock_cnt;
  logic              press_det;
  logic [CODE_W-1:0] press_code;
  logic              press_multi;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [CODE_W:0]   head;

  assign lockout_active = (lock_cnt != '0);
  assign press_det      = enable && !lockout_active && (|press_pulse);
  assign press_multi    = |(press_pulse & (press_pulse - 1'b1));
  assign pop            = evt.valid && evt.ready;

  // Lowest-numbered button wins when several pulse together.
  always_comb begin
    press_code = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (press_pulse[i]) press_code = CODE_W'(i);
    end
  end

  always_ff @(posedge clock_signal or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt <= '0;
    end else if (flush) begin
      lock_cnt <= '0;
    end else if (press_det) begin
      lock_cnt <= LOCK_W'(LOCKOUT_CYCLES);
    end else if (lockout_active) begin
      lock_cnt <= lock_cnt - 1'b1;
    end
  end

  always_ff @(posedge clock_signal or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if (press_det && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  event_fifo #(
    .WIDTH (CODE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_signal (clock_signal),
    .reset_n      (reset_n),
    .flush        (flush),
    .push         (press_det),
    .push_data    ({press_code, press_multi}),
    .pop          (pop),
    .pop_data     (head),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .count        (event_count)
  );

  assign evt.valid = !fifo_empty;
  assign evt.code  = head[CODE_W:1];
  assign evt.multi = head[0];

endmodule

// File: tb/tb_button_event_queue.sv
// Bench for button_event_queue: directed scenarios plus randomized traffic against a queue model.
module tb_button_event_queue;
  import simon_pkg::*;

  localparam int LK = 8;
  localparam int DEPTH = 4;

  logic       clock_signal = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] pulse = '0;
  logic       enable = 1'b1;
  logic       flush = 1'b0;
  logic       lock_a, ovf_a;
  logic [2:0] cnt_a;

  logic [3:0] p1 = '0;
  logic       en1 = 1'b1;
  logic       fl1 = 1'b0;
  logic       lock_b, ovf_b;
  logic [2:0] cnt_b;

  int tests = 0;
  int fails = 0;

  button_event_queue_if #(.CODE_W(2)) ev ();
  button_event_queue_if #(.CODE_W(2)) ev1 ();

  button_event_queue #(.NUM_BUTTONS(4), .LOCKOUT_CYCLES(LK), .FIFO_DEPTH(DEPTH)) dut (
    .clock_signal (clock_signal), .reset_n (reset_n), .press_pulse (pulse),
    .enable (enable), .flush (flush), .evt (ev),
    .lockout_active (lock_a), .overflow (ovf_a), .event_count (cnt_a)
  );

  button_event_queue #(.NUM_BUTTONS(4), .LOCKOUT_CYCLES(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clock_signal (clock_signal), .reset_n (reset_n), .press_pulse (p1),
    .enable (en1), .flush (fl1), .evt (ev1),
    .lockout_active (lock_b), .overflow (ovf_b), .event_count (cnt_b)
  );

  always #5 clock_signal = ~clock_signal;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // Reference model for dut: events queue, lockout cycles remaining, sticky overflow.
  event_t mq[$];
  int     mlock = 0;
  bit     movf = 1'b0;

  always @(posedge clock_signal or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete(); mlock = 0; movf = 1'b0;
    end else begin
      bit det, popped;
      event_t e;
      det = enable && (mlock == 0) && (pulse != 0);
      popped = (mq.size() > 0) && ev.ready;
      if (flush) begin
        mq.delete(); mlock = 0; movf = 1'b0;
      end else begin
        if (popped) void'(mq.pop_front());
        if (det) begin
          for (int i = 3; i >= 0; i--) if (pulse[i]) e.code = colour_t'(i[1:0]);
          e.multi = ($countones(pulse) > 1);
          if (mq.size() < DEPTH) mq.push_back(e); else movf = 1'b1;
          mlock = LK;
        end else if (mlock > 0) begin
          mlock = mlock - 1;
        end
      end
    end
  end

  task automatic quiesce();
    @(negedge clock_signal);
    pulse = '0; enable = 1'b1; flush = 1'b0; ev.ready = 1'b1;
    repeat (LK + 2) @(negedge clock_signal);
    ev.ready = 1'b0;
  endtask

  task automatic press(input logic [3:0] pat);
    @(negedge clock_signal) pulse = pat;
    @(negedge clock_signal) pulse = '0;
    repeat (LK) @(negedge clock_signal);
  endtask

  task automatic test_reset();
    ev.ready = 1'b0; ev1.ready = 1'b0;
    repeat (3) @(negedge clock_signal);
    tests++; if ({ev.valid, ev.code, ev.multi} !== 4'b0) begin fails++; $display("FAIL reset_head: got %b expected 0000", {ev.valid, ev.code, ev.multi}); end
    tests++; if ({cnt_a, lock_a, ovf_a} !== 5'b0) begin fails++; $display("FAIL reset_status: got %b expected 00000", {cnt_a, lock_a, ovf_a}); end
    tests++; if ({ev1.valid, ev1.code, ev1.multi, cnt_b, lock_b, ovf_b} !== 9'b0) begin fails++; $display("FAIL reset_dut1: got %b expected 0", {ev1.valid, ev1.code, ev1.multi, cnt_b, lock_b, ovf_b}); end
    reset_n = 1'b1;
  endtask

  task automatic test_single_press();
    quiesce();
    @(negedge clock_signal) pulse = 4'b0100;
    @(negedge clock_signal) pulse = '0;
    tests++; if ({ev.valid, ev.code, ev.multi} !== 4'b1100) begin fails++; $display("FAIL single_head: got %b expected 1100", {ev.valid, ev.code, ev.multi}); end
    for (int i = 0; i <= LK; i++) begin
      tests++; if (lock_a !== (i < LK)) begin fails++; $display("FAIL single_lockout[%0d]: got %b expected %b", i, lock_a, (i < LK)); end
      @(negedge clock_signal);
    end
  endtask

  task automatic test_bounce();
    quiesce();
    for (int k = 0; k <= 10; k++) begin
      @(negedge clock_signal);
      pulse = (k == 0 || k == 2 || k == 7 || k == 9) ? 4'b0001 : 4'b0000;
      if (k == 9) begin
        tests++; if (cnt_a !== 3'd1) begin fails++; $display("FAIL bounce_count_one: got %0d expected 1", cnt_a); end
      end
    end
    tests++; if (cnt_a !== 3'd2) begin fails++; $display("FAIL bounce_count_two: got %0d expected 2", cnt_a); end
  endtask

  task automatic test_multi();
    quiesce();
    @(negedge clock_signal) pulse = 4'b1010;
    @(negedge clock_signal) pulse = '0;
    tests++; if ({ev.valid, ev.code, ev.multi} !== 4'b1011) begin fails++; $display("FAIL multi_head: got %b expected 1011", {ev.valid, ev.code, ev.multi}); end
  endtask

  task automatic test_order();
    logic [1:0] exp_codes [3];
    exp_codes[0] = 2'd3; exp_codes[1] = 2'd0; exp_codes[2] = 2'd2;
    quiesce();
    press(4'b1000); press(4'b0001); press(4'b0100);
    for (int i = 0; i < 5; i++) begin
      tests++; if ({ev.valid, ev.code, cnt_a} !== {1'b1, 2'd3, 3'd3}) begin fails++; $display("FAIL order_hold: got %b expected 111011", {ev.valid, ev.code, cnt_a}); end
      @(negedge clock_signal);
    end
    ev.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++; if ({ev.valid, ev.code} !== {1'b1, exp_codes[i]}) begin fails++; $display("FAIL order_pop[%0d]: got %b expected %b", i, {ev.valid, ev.code}, {1'b1, exp_codes[i]}); end
      @(negedge clock_signal);
    end
    tests++; if (ev.valid !== 1'b0) begin fails++; $display("FAIL order_empty: got %b expected 0", ev.valid); end
    ev.ready = 1'b0;
  endtask

  task automatic test_flush();
    quiesce();
    press(4'b0001); press(4'b0010);
    tests++; if (cnt_a !== 3'd2) begin fails++; $display("FAIL flush_pre_count: got %0d expected 2", cnt_a); end
    pulse = 4'b0100; flush = 1'b1;
    @(negedge clock_signal) pulse = '0; flush = 1'b0;
    tests++; if ({ev.valid, cnt_a, lock_a, ovf_a} !== 6'b0) begin fails++; $display("FAIL flush_clear: got %b expected 000000", {ev.valid, cnt_a, lock_a, ovf_a}); end
    pulse = 4'b0010;
    @(negedge clock_signal) pulse = '0;
    tests++; if ({ev.valid, ev.code} !== 3'b101) begin fails++; $display("FAIL flush_then_press: got %b expected 101", {ev.valid, ev.code}); end
  endtask

  task automatic test_overflow();
    logic [3:0] pats [5];
    logic [1:0] exp_codes [4];
    pats[0] = 4'b0001; pats[1] = 4'b0010; pats[2] = 4'b0100; pats[3] = 4'b1000; pats[4] = 4'b0001;
    exp_codes[0] = 2'd1; exp_codes[1] = 2'd2; exp_codes[2] = 2'd3; exp_codes[3] = 2'd2;
    ev1.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_signal) p1 = pats[i];
      @(negedge clock_signal) p1 = '0;
      @(negedge clock_signal);
      if (i == 3) begin
        tests++; if ({cnt_b, ovf_b} !== {3'd4, 1'b0}) begin fails++; $display("FAIL ovf_full_no_drop: got %b expected 1000", {cnt_b, ovf_b}); end
      end
    end
    tests++; if ({cnt_b, ovf_b, ev1.valid, ev1.code} !== {3'd4, 1'b1, 1'b1, 2'd0}) begin fails++; $display("FAIL ovf_drop: got %b expected 1001100", {cnt_b, ovf_b, ev1.valid, ev1.code}); end
    p1 = 4'b0100; ev1.ready = 1'b1;
    @(negedge clock_signal) p1 = '0;
    tests++; if ({cnt_b, ev1.code} !== {3'd4, 2'd1}) begin fails++; $display("FAIL ovf_pop_push: got %b expected 10001", {cnt_b, ev1.code}); end
    for (int i = 0; i < 4; i++) begin
      tests++; if ({ev1.valid, ev1.code} !== {1'b1, exp_codes[i]}) begin fails++; $display("FAIL ovf_drain[%0d]: got %b expected %b", i, {ev1.valid, ev1.code}, {1'b1, exp_codes[i]}); end
      @(negedge clock_signal);
    end
    tests++; if ({ev1.valid, cnt_b, ovf_b} !== {1'b0, 3'd0, 1'b1}) begin fails++; $display("FAIL ovf_sticky: got %b expected 00001", {ev1.valid, cnt_b, ovf_b}); end
    ev1.ready = 1'b0; fl1 = 1'b1;
    @(negedge clock_signal) fl1 = 1'b0;
    tests++; if (ovf_b !== 1'b0) begin fails++; $display("FAIL ovf_flush: got %b expected 0", ovf_b); end
  endtask

  task automatic test_random();
    logic [1:0] exp_code;
    logic       exp_multi;
    quiesce();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock_signal);
      exp_code  = (mq.size() > 0) ? mq[0].code : 2'd0;
      exp_multi = (mq.size() > 0) ? mq[0].multi : 1'b0;
      tests++; if (ev.valid !== (mq.size() > 0)) begin fails++; $display("FAIL rand_valid@%0d: got %b expected %b", c, ev.valid, (mq.size() > 0)); end
      tests++; if ({ev.code, ev.multi} !== {exp_code, exp_multi}) begin fails++; $display("FAIL rand_head@%0d: got %b expected %b", c, {ev.code, ev.multi}, {exp_code, exp_multi}); end
      tests++; if (cnt_a !== 3'(mq.size())) begin fails++; $display("FAIL rand_count@%0d: got %0d expected %0d", c, cnt_a, mq.size()); end
      tests++; if ({lock_a, ovf_a} !== {(mlock > 0), movf}) begin fails++; $display("FAIL rand_status@%0d: got %b expected %b", c, {lock_a, ovf_a}, {(mlock > 0), movf}); end
      pulse    = ($urandom_range(0, 9) < 4) ? 4'($urandom_range(1, 15)) : 4'b0;
      enable   = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 99) < 2);
      ev.ready = ($urandom_range(0, 9) < 3);
    end
    @(negedge clock_signal);
    pulse = '0; enable = 1'b1; flush = 1'b0; ev.ready = 1'b0;
  endtask

  task automatic test_async_reset();
    quiesce();
    @(negedge clock_signal) pulse = 4'b0010;
    @(negedge clock_signal) pulse = '0;
    tests++; if ({lock_a, ev.valid} !== 2'b11) begin fails++; $display("FAIL areset_pre: got %b expected 11", {lock_a, ev.valid}); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if ({ev.valid, ev.code, ev.multi, cnt_a, lock_a, ovf_a} !== 9'b0) begin fails++; $display("FAIL areset_outputs: got %b expected 0", {ev.valid, ev.code, ev.multi, cnt_a, lock_a, ovf_a}); end
    @(negedge clock_signal) reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_order();
    test_flush();
    test_overflow();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
